updown_counter_param: RTL and testbench
=======================================

// Module: updown_counter_param
// PURPOSE
//   Parametrised up/down counter with programmable modulus, parallel load, wrap/saturate
//   mode and an enable prescaler. Next-generation general-purpose counter for the sample
//   designs: it replaces fixed 4-bit up-only counters in timers, sequencers and testbenches.
// PARAMETERS
//   WIDTH     8               counter width in bits (>=2)
//   MAX_VAL   (1<<WIDTH)-1    terminal value; count range is 0..MAX_VAL (must be < 2**WIDTH)
//   PRESCALE  1               number of en-high cycles per count step (>=1; 1 = no prescale)
// PORTS
//   clk       in   1      clock; all state changes on posedge clk
//   rst       in   1      reset, synchronous, active-high
//   en        in   1      count enable; feeds the prescaler
//   up_dn     in   1      1 = count up, 0 = count down
//   sat_mode  in   1      1 = saturate at the limits, 0 = wrap modulo MAX_VAL+1
//   load      in   1      parallel load strobe
//   load_val  in   WIDTH  value to load
//   count     out  WIDTH  current count (registered)
//   wrap      out  1      1-cycle pulse: the count wrapped (MAX_VAL->0 or 0->MAX_VAL)
//   sat       out  1      1-cycle pulse: a step was blocked at a limit (sat_mode=1)
//   at_max    out  1      count == MAX_VAL (combinational from count)
//   at_min    out  1      count == 0 (combinational from count)
// BEHAVIOUR
//   - Reset: clk and rst are the only clock and reset. With rst=1 at posedge clk: count=0,
//     wrap=0, sat=0, prescaler=0. rst has priority over every other input.
//   - Priority: rst > load > step. Step = en && prescaler at terminal.
//   - Prescaler: pre_cnt counts 0..PRESCALE-1 on en=1 and holds on en=0. A step is taken in
//     the cycle where en=1 and pre_cnt==PRESCALE-1; pre_cnt then returns to 0. With
//     PRESCALE=1, step=en. load clears pre_cnt.
//   - Load: count <= min(load_val, MAX_VAL) on the next edge. wrap=0 and sat=0 in that cycle.
//   - Up step: if count<MAX_VAL then count+1. At MAX_VAL: wrap mode -> 0 with wrap=1;
//     sat mode -> hold with sat=1.
//   - Down step: if count>0 then count-1. At 0: wrap mode -> MAX_VAL with wrap=1;
//     sat mode -> hold with sat=1.
//   - Latency: one cycle. wrap and sat are registered and are high in the same cycle that
//     count shows the post-step value. Both are 0 in every cycle without a limit event.
//   - Non-power-of-2 MAX_VAL: never generate a value > MAX_VAL. Compute in WIDTH+1 bits
//     internally so no silent 2**WIDTH rollover occurs.
//   - up_dn and sat_mode may change on any cycle and take effect on the next step.
//   - rst asserted mid-prescale or mid-load: reset state wins, and no pulse is emitted.
// CONFIGURATION
//   UPDN_CNT_MATCH_EN defined: adds input cmp_val[WIDTH] and output match (1). match is a
//     registered 1-cycle pulse, high in the cycle count first becomes equal to cmp_val after
//     a step or a load. It is not re-asserted while count holds (e.g. saturated or en=0).
//     Reset value is 0.
//   UPDN_CNT_MATCH_EN undefined: cmp_val and match do not exist and there is no compare
//     logic.
// STRUCTURE
//   updown_counter_pkg holds:
//     - localparams for the up/down encoding (CNT_UP=1'b1, CNT_DN=1'b0)
//     - localparams for the mode encoding (MODE_WRAP=1'b0, MODE_SAT=1'b1)
//     - a function clamp(val, max)
//   Sub-module cnt_prescaler (param PRESCALE; ports clk, rst, en, clr, tick) produces the
//     step strobe. The top-level block holds the count register, the limit logic and the
//     optional match logic.
// TESTING  (WIDTH=4, MAX_VAL=9, PRESCALE=1 unless stated)
//   1 rst=1 for 2 cycles with en=1 -> count=0, wrap=0, sat=0. After release, up, wrap mode,
//     12 steps -> 1..9,0,1,2, wrap=1 only on the 9->0 cycle.
//   2 Down, wrap mode, starting at 0 -> next count=9 with wrap=1, then 8. With sat_mode=1 at
//     count=0 -> count holds 0 and sat=1 on each step.
//   3 load=1, load_val=13 -> count=9 (clamped). load and en together with load_val=4 -> count=4,
//     no step taken.
//   4 PRESCALE=3, en=1 continuously -> count increments every 3rd cycle. Drop en for 2 cycles
//     mid-prescale -> phase is held and the increment is delayed by exactly 2 cycles.
//   5 rst=1 in the same cycle as load=1 and a step at count=9 -> count=0 and wrap=0.
//   6 With UPDN_CNT_MATCH_EN and cmp_val=5, count up from 0 -> match=1 for exactly one cycle
//     when count=5. Saturate at 9 with cmp_val=9 -> match pulses once only.

Source files
------------

// File: rtl/updown_counter_pkg.sv
// rtl/updown_counter_pkg.sv - shared encodings and helpers for the up/down counter
package updown_counter_pkg;

  localparam logic CNT_UP    = 1'b1;
  localparam logic CNT_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  function automatic int unsigned clamp(input int unsigned val, input int unsigned max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// rtl/cnt_prescaler.sv - divides en into one tick per PRESCALE enabled cycles
module cnt_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  // With PRESCALE=1 pre_cnt never leaves 0, so tick degenerates to en.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] TERM = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;

  assign tick = en && (pre_cnt == TERM);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - up/down counter with modulus, load, wrap/saturate, prescaler
// Optional compare output enabled by defining UPDN_CNT_MATCH_EN.
module updown_counter_param
  import updown_counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef UPDN_CNT_MATCH_EN
  input  logic [WIDTH-1:0] cmp_val,
  output logic             match,
`endif
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             sat,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH:0] MAX_EXT = (WIDTH + 1)'(MAX_VAL);
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH + 1)'(1);

  logic             tick;
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   nxt_ext;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             sat_nxt;

  cnt_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  // One guard bit keeps +1 at a non-power-of-2 limit from silently rolling over.
  always_comb begin
    cnt_ext  = {1'b0, count};
    nxt_ext  = cnt_ext;
    wrap_nxt = 1'b0;
    sat_nxt  = 1'b0;
    if (load) begin
      nxt_ext = (WIDTH + 1)'(clamp(32'(load_val), MAX_VAL));
    end else if (tick) begin
      if (up_dn == CNT_UP) begin
        if (cnt_ext < MAX_EXT) begin
          nxt_ext = cnt_ext + ONE_EXT;
        end else if (sat_mode == MODE_SAT) begin
          sat_nxt = 1'b1;
        end else begin
          nxt_ext  = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (cnt_ext != '0) begin
          nxt_ext = cnt_ext - ONE_EXT;
        end else if (sat_mode == MODE_SAT) begin
          sat_nxt = 1'b1;
        end else begin
          nxt_ext  = MAX_EXT;
          wrap_nxt = 1'b1;
        end
      end
    end
    count_nxt = WIDTH'(nxt_ext);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wrap  <= 1'b0;
      sat   <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
      sat   <= sat_nxt;
    end
  end

`ifdef UPDN_CNT_MATCH_EN
  // Only a change of value can raise match, so a holding count never re-fires it.
  always_ff @(posedge clk) begin
    if (rst) begin
      match <= 1'b0;
    end else begin
      match <= (count_nxt != count) && (count_nxt == cmp_val);
    end
  end
`endif

  assign at_max = (cnt_ext == MAX_EXT);
  assign at_min = (count == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - checks two counter instances (PRESCALE 1 and 3) against a model
module tb_updown_counter_param;

  localparam int W  = 4;
  localparam int MX = 9;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, up_dn = 1'b1, sat_mode = 1'b0, load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] count_a, count_b;
  logic wrap_a, wrap_b, sat_a, sat_b, at_max_a, at_max_b, at_min_a, at_min_b;
`ifdef UPDN_CNT_MATCH_EN
  logic [W-1:0] cmp_val = '0;
  logic match_a, match_b;
  int m_match [2];
`endif

  int errors = 0;
  int checks = 0;
  int m_cnt  [2];
  int m_pre  [2];
  int m_wrap [2];
  int m_sat  [2];
  int ps     [2] = '{1, 3};

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(W), .MAX_VAL(MX), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val),
`ifdef UPDN_CNT_MATCH_EN
    .cmp_val(cmp_val), .match(match_a),
`endif
    .count(count_a), .wrap(wrap_a), .sat(sat_a), .at_max(at_max_a), .at_min(at_min_a)
  );

  updown_counter_param #(.WIDTH(W), .MAX_VAL(MX), .PRESCALE(3)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat_mode(sat_mode),
    .load(load), .load_val(load_val),
`ifdef UPDN_CNT_MATCH_EN
    .cmp_val(cmp_val), .match(match_b),
`endif
    .count(count_b), .wrap(wrap_b), .sat(sat_b), .at_max(at_max_b), .at_min(at_min_b)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: counting modulo MX+1, prescaler as a phase counter over enabled cycles.
  task automatic model_edge(input int i);
    int nxt;
    if (rst) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_wrap[i] = 0; m_sat[i] = 0;
`ifdef UPDN_CNT_MATCH_EN
      m_match[i] = 0;
`endif
      return;
    end
    nxt = m_cnt[i];
    m_wrap[i] = 0;
    m_sat[i]  = 0;
    if (load) begin
      nxt = (int'(load_val) > MX) ? MX : int'(load_val);
      m_pre[i] = 0;
    end else if (en) begin
      m_pre[i] = (m_pre[i] + 1) % ps[i];
      if (m_pre[i] == 0) begin
        if (up_dn) begin
          if (m_cnt[i] == MX && sat_mode) m_sat[i] = 1;
          else begin
            nxt = (m_cnt[i] + 1) % (MX + 1);
            m_wrap[i] = (m_cnt[i] == MX) ? 1 : 0;
          end
        end else begin
          if (m_cnt[i] == 0 && sat_mode) m_sat[i] = 1;
          else begin
            nxt = (m_cnt[i] + MX) % (MX + 1);
            m_wrap[i] = (m_cnt[i] == 0) ? 1 : 0;
          end
        end
      end
    end
`ifdef UPDN_CNT_MATCH_EN
    m_match[i] = (nxt != m_cnt[i] && nxt == int'(cmp_val)) ? 1 : 0;
`endif
    m_cnt[i] = nxt;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check("count_a", int'(count_a), m_cnt[0]);
    check("wrap_a", int'(wrap_a), m_wrap[0]);
    check("sat_a", int'(sat_a), m_sat[0]);
    check("at_max_a", int'(at_max_a), (m_cnt[0] == MX) ? 1 : 0);
    check("at_min_a", int'(at_min_a), (m_cnt[0] == 0) ? 1 : 0);
    check("count_b", int'(count_b), m_cnt[1]);
    check("wrap_b", int'(wrap_b), m_wrap[1]);
    check("sat_b", int'(sat_b), m_sat[1]);
    check("at_max_b", int'(at_max_b), (m_cnt[1] == MX) ? 1 : 0);
    check("at_min_b", int'(at_min_b), (m_cnt[1] == 0) ? 1 : 0);
`ifdef UPDN_CNT_MATCH_EN
    check("match_a", int'(match_a), m_match[0]);
    check("match_b", int'(match_b), m_match[1]);
`endif
  endtask

  task automatic do_load(input int v);
    load = 1'b1; load_val = W'(v);
    cycle();
    load = 1'b0;
  endtask

  initial begin
    // Reset with en held high
    rst = 1'b1; en = 1'b1;
    repeat (2) cycle();
    check("reset_count", int'(count_a), 0);
    check("reset_wrap", int'(wrap_a), 0);
    check("reset_sat", int'(sat_a), 0);

    // Up count in wrap mode across the 9 -> 0 boundary
    rst = 1'b0; up_dn = 1'b1; sat_mode = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      check("up_seq", int'(count_a), k % 10);
      check("up_wrap", int'(wrap_a), (k == 10) ? 1 : 0);
    end

    // Down from 0 in wrap mode, then in saturate mode
    en = 1'b0; do_load(0);
    en = 1'b1; up_dn = 1'b0;
    cycle(); check("dn_wrap_val", int'(count_a), 9); check("dn_wrap_pulse", int'(wrap_a), 1);
    cycle(); check("dn_after_wrap", int'(count_a), 8);
    en = 1'b0; do_load(0);
    en = 1'b1; sat_mode = 1'b1;
    repeat (3) begin
      cycle(); check("dn_sat_hold", int'(count_a), 0); check("dn_sat_pulse", int'(sat_a), 1);
    end

    // Load clamps above MAX_VAL, and load beats a simultaneous step
    en = 1'b0; do_load(13);
    check("load_clamp", int'(count_a), 9);
    en = 1'b1; up_dn = 1'b1; do_load(4);
    check("load_over_step", int'(count_a), 4);

    // Prescaled instance: continuous enable, then a 2-cycle pause mid-prescale
    rst = 1'b1; cycle(); rst = 1'b0;
    en = 1'b1; sat_mode = 1'b0;
    repeat (7) cycle();
    check("pre3_count", int'(count_b), 2);
    en = 1'b0; repeat (2) cycle();
    en = 1'b1; cycle();
    check("pre3_paused", int'(count_b), 2);
    cycle();
    check("pre3_resumed", int'(count_b), 3);

    // Reset coinciding with load and a wrapping step
    en = 1'b0; do_load(9);
    rst = 1'b1; load = 1'b1; load_val = W'(3); en = 1'b1; up_dn = 1'b1;
    cycle();
    check("rst_prio_count", int'(count_a), 0);
    check("rst_prio_wrap", int'(wrap_a), 0);
    rst = 1'b0; load = 1'b0;

`ifdef UPDN_CNT_MATCH_EN
    cmp_val = W'(5);
    for (int k = 1; k <= 8; k++) begin
      cycle(); check("match5", int'(match_a), (k == 5) ? 1 : 0);
    end
    cmp_val = W'(9); sat_mode = 1'b1;
    for (int k = 9; k <= 13; k++) begin
      cycle(); check("match9_once", int'(match_a), (k == 9) ? 1 : 0);
    end
`endif

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      rst      = ($urandom_range(0, 49) == 0);
      load     = ($urandom_range(0, 11) == 0);
      load_val = W'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = ($urandom_range(0, 3) != 0);
      sat_mode = $urandom_range(0, 1) != 0;
`ifdef UPDN_CNT_MATCH_EN
      cmp_val  = W'($urandom_range(0, 9));
`endif
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
